sqrt_arbiter: RTL

Shares one multi-cycle single-precision sqrt core among NUM_REQ requesters, such as the collision-detection distance units. Requests are arbitrated round-robin. The block issues a one-cycle start to the core, waits for done under a watchdog, and returns the result to the granted requester on a held valid/ready response channel. IEEE-754 special operands bypass the core entirely.

---
 rtl/sqrt_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// sqrt_arbiter
// Shares one multi-cycle single-precision sqrt core among NUM_REQ requesters.
// Requests are granted round-robin one at a time. IEEE-754 special operands
// (zeros, infinities, NaNs, negatives) are answered locally without the core.
// Normal operands get a one-cycle start pulse to the core. The arbiter then
// waits for done under a watchdog and returns the result on a held
// valid/ready response channel.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  one-hot accept pulse (combinational, IDLE only)
//   req_n      packed operands, requester i at [32i+31:32i]
//   rsp_valid  one-hot response valid, held until rsp_ready of that line
//   rsp_ready  per-requester response accept
//   rsp_res    result (registered)
//   rsp_err    1 = watchdog timeout (registered)
//   sq_start   one-cycle start to the sqrt core
//   sq_n       core operand (registered, held until the next normal accept)
//   sq_done    core result-valid pulse
//   sq_res     core result, sampled when sq_done=1
//   busy       1 whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module sqrt_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [32*NUM_REQ-1:0]  req_n,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [31:0]            rsp_res,
   output logic                   rsp_err,
   output logic                   sq_start,
   output logic [31:0]            sq_n,
   input  logic                   sq_done,
   input  logic [31:0]            sq_res,
   output logic                   busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [31:0]      QNAN     = 32'h7FC0_0000;
   localparam logic [31:0]      PINF     = 32'h7F80_0000;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] gnt_q, gnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      sq_n_q, sq_n_d;
   logic [31:0]      res_q, res_d;
   logic             err_q, err_d;

   // Special operands: any sign bit set, exponent all ones, or magnitude zero.
   function automatic logic is_special(input logic [31:0] x);
      return x[31] || (x[30:23] == 8'hFF) || (x[30:0] == 31'd0);
   endfunction

   function automatic logic [31:0] special_res(input logic [31:0] x);
      if (x[30:0] == 31'd0)      return x;      // signed zero passes through
      else if (x[31])            return QNAN;   // negative nonzero, incl. -Inf
      else if (x[22:0] != 23'd0) return QNAN;   // NaN
      else                       return PINF;
   endfunction

   // Unpacked view of the operand bus so the granted operand is a plain index.
   logic [31:0] ops [NUM_REQ];
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
      assign ops[i] = req_n[32*i +: 32];
   end

   // Round-robin pick: first valid line strictly after last_q, wrapping.
   int               cand;
   logic [IDX_W-1:0] cand_idx;
   logic             found;
   logic [IDX_W-1:0] pick;
   logic [31:0]      pick_op;

   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cand     = 0;
      cand_idx = '0;
      found    = 1'b0;
      pick     = last_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand     = (int'(last_q) + k) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!found && req_valid[cand_idx]) begin
            found = 1'b1;
            pick  = cand_idx;
         end
      end
   end

   assign pick_op = ops[pick];

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      sq_n_d    = sq_n_q;
      res_d     = res_q;
      err_d     = err_q;
      req_ready = '0;
      unique case (state_q)
         S_IDLE: begin
            // Gated by RST so no accept is signalled while held in reset.
            if (found && RST) begin
               req_ready[pick] = 1'b1;
               gnt_d           = pick;
               if (is_special(pick_op)) begin
                  res_d   = special_res(pick_op);
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end else begin
                  sq_n_d  = pick_op;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // done is checked first so it wins over a coincident timeout
            if (sq_done) begin
               res_d   = sq_res;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               res_d   = QNAN;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready[gnt_q]) begin
               last_d  = gnt_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         last_q  <= IDX_W'(NUM_REQ - 1);
         gnt_q   <= '0;
         cnt_q   <= '0;
         sq_n_q  <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         sq_n_q  <= sq_n_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (state_q == S_RESP) rsp_valid[gnt_q] = 1'b1;
   end

   assign sq_start = (state_q == S_ISSUE);
   assign busy     = (state_q != S_IDLE);
   assign sq_n     = sq_n_q;
   assign rsp_res  = res_q;
   assign rsp_err  = err_q;

endmodule
